pwm_mixer_n: RTL and testbench



---
 rtl/pwm_mixer_pkg.sv | 32 +++
 rtl/pwm_mixer_n_if.sv | 23 ++
 rtl/pwm_mixer_n_encoder_channel.sv | 74 +++++++
 rtl/pwm_mixer_n.sv | 63 ++++++
 tb/tb_pwm_mixer_n.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/pwm_mixer_pkg.sv
// Shared constants, quadrature step type and level arithmetic for pwm_mixer_n.
package pwm_mixer_pkg;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned LEVEL_MAX_W = 12;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN
  } step_e;

  // Operates on the widest supported level; callers truncate to their own width.
  function automatic logic [LEVEL_MAX_W-1:0] sat_step(
    input logic [LEVEL_MAX_W-1:0] level,
    input step_e                  step,
    input logic                   saturate,
    input int unsigned            width
  );
    logic [LEVEL_MAX_W-1:0] lvl_max;
    logic [LEVEL_MAX_W-1:0] res;
    lvl_max = {LEVEL_MAX_W{1'b1}} >> (LEVEL_MAX_W - width);
    res     = level;
    case (step)
      STEP_UP:   if (!(saturate && (level == lvl_max))) res = (level + 1'b1) & lvl_max;
      STEP_DOWN: if (!(saturate && (level == '0)))      res = (level - 1'b1) & lvl_max;
      default:   res = level;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pwm_mixer_n_if.sv
// Pad-side and readback signals of pwm_mixer_n, grouped for the wrapper.
interface pwm_mixer_n_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned WIDTH  = 8
);
  logic                    enable;
  logic [NUM_CH-1:0]       enc_a;
  logic [NUM_CH-1:0]       enc_b;
  logic [NUM_CH-1:0]       pwm_out;
  logic                    sync;
  logic [NUM_CH*WIDTH-1:0] level_o;
  logic [NUM_CH:0]         io_oeb;

  modport master (
    output enable, enc_a, enc_b,
    input  pwm_out, sync, level_o, io_oeb
  );

  modport slave (
    input  enable, enc_a, enc_b,
    output pwm_out, sync, level_o, io_oeb
  );
endinterface

// File: rtl/pwm_mixer_n_encoder_channel.sv
// One encoder/PWM lane: synchroniser, tick-sampled debounce, A-edge decode,
// level register, per-period duty latch and registered PWM compare.
module encoder_channel
  import pwm_mixer_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          SATURATE   = 1'b1,
  parameter int unsigned INIT_LEVEL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             enc_a_i,
  input  logic             enc_b_i,
  output logic             pwm_o,
  output logic [WIDTH-1:0] level_o
);

  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
  logic                   a_samp_q, b_samp_q;
  logic                   a_deb_q, b_deb_q, a_deb_last_q;
  logic [WIDTH-1:0]       level_q, level_d;
  logic [WIDTH-1:0]       duty_q, duty_cmp;
  logic                   pwm_q;
  logic                   a_s, b_s, cnt_zero;
  step_e                  step;

  assign a_s      = a_sync_q[SYNC_STAGES-1];
  assign b_s      = b_sync_q[SYNC_STAGES-1];
  assign cnt_zero = (cnt_i == '0);
  // The new duty must already apply on the counter==0 cycle so pwm aligns with sync.
  assign duty_cmp = cnt_zero ? level_q : duty_q;

  always_comb begin
    step = STEP_NONE;
    if (a_deb_q && !a_deb_last_q) step = b_deb_q ? STEP_DOWN : STEP_UP;
  end

  assign level_d = WIDTH'(sat_step(LEVEL_MAX_W'(level_q), step, SATURATE, WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sync_q     <= '0;
      b_sync_q     <= '0;
      a_samp_q     <= 1'b0;
      b_samp_q     <= 1'b0;
      a_deb_q      <= 1'b0;
      b_deb_q      <= 1'b0;
      a_deb_last_q <= 1'b0;
      level_q      <= WIDTH'(INIT_LEVEL);
      duty_q       <= '0;
      pwm_q        <= 1'b0;
    end else begin
      a_sync_q     <= {a_sync_q[SYNC_STAGES-2:0], enc_a_i};
      b_sync_q     <= {b_sync_q[SYNC_STAGES-2:0], enc_b_i};
      a_deb_last_q <= a_deb_q;
      if (tick_i) begin
        a_samp_q <= a_s;
        b_samp_q <= b_s;
        if (a_s == a_samp_q) a_deb_q <= a_s;
        if (b_s == b_samp_q) b_deb_q <= b_s;
      end
      if (enable_i) level_q <= level_d;
      if (cnt_zero) duty_q <= level_q;
      pwm_q <= enable_i && (cnt_i < duty_cmp);
    end
  end

  assign pwm_o   = pwm_q;
  assign level_o = level_q;

endmodule

// File: rtl/pwm_mixer_n.sv
// NUM_CH encoder-driven PWM channels sharing one debounce prescaler and one
// PWM period counter; sync marks the first cycle of each period.
module pwm_mixer_n
  import pwm_mixer_pkg::*;
#(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEBOUNCE_DIV = 64,
  parameter int unsigned SATURATE     = 1,
  parameter int unsigned INIT_LEVEL   = 0
) (
  input  logic          clk,
  input  logic          reset,
  pwm_mixer_n_if.slave  bus
);

  localparam int unsigned PW = $clog2(DEBOUNCE_DIV);

  logic [PW-1:0]                  presc_q;
  logic                           tick;
  logic [WIDTH-1:0]               cnt_q;
  logic                           sync_q;
  logic [NUM_CH-1:0]              pwm;
  logic [NUM_CH-1:0][WIDTH-1:0]   lvl;

  assign tick = (presc_q == PW'(DEBOUNCE_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      cnt_q   <= '0;
      sync_q  <= 1'b0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      cnt_q   <= bus.enable ? cnt_q + WIDTH'(1) : '0;
      sync_q  <= bus.enable && (cnt_q == '0);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    encoder_channel #(
      .WIDTH      (WIDTH),
      .SATURATE   (SATURATE != 0),
      .INIT_LEVEL (INIT_LEVEL)
    ) u_ch (
      .clk      (clk),
      .rst      (reset),
      .tick_i   (tick),
      .enable_i (bus.enable),
      .cnt_i    (cnt_q),
      .enc_a_i  (bus.enc_a[i]),
      .enc_b_i  (bus.enc_b[i]),
      .pwm_o    (pwm[i]),
      .level_o  (lvl[i])
    );
  end

  assign bus.pwm_out = pwm;
  assign bus.sync    = sync_q;
  assign bus.level_o = lvl;
  assign bus.io_oeb  = '0;

endmodule

// File: tb/tb_pwm_mixer_n.sv
// Directed bench: saturating DUT (init 0), wrapping DUT (init 0) and a
// saturating DUT starting at 253, all with WIDTH=8 and DEBOUNCE_DIV=4.
module tb_pwm_mixer_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] ea [3];
  logic [2:0] eb [3];

  int checks = 0;
  int errors = 0;
  int run_hi [3];
  int last_hi [3];
  int sync_cnt = 0;

  pwm_mixer_n_if #(.NUM_CH(3), .WIDTH(8)) ifs ();
  pwm_mixer_n_if #(.NUM_CH(3), .WIDTH(8)) ifw ();
  pwm_mixer_n_if #(.NUM_CH(3), .WIDTH(8)) ifh ();

  assign ifs.enable = en;  assign ifs.enc_a = ea[0];  assign ifs.enc_b = eb[0];
  assign ifw.enable = en;  assign ifw.enc_a = ea[1];  assign ifw.enc_b = eb[1];
  assign ifh.enable = en;  assign ifh.enc_a = ea[2];  assign ifh.enc_b = eb[2];

  pwm_mixer_n #(.NUM_CH(3), .WIDTH(8), .DEBOUNCE_DIV(4), .SATURATE(1), .INIT_LEVEL(0))
    u_s (.clk(clk), .reset(rst), .bus(ifs.slave));
  pwm_mixer_n #(.NUM_CH(3), .WIDTH(8), .DEBOUNCE_DIV(4), .SATURATE(0), .INIT_LEVEL(0))
    u_w (.clk(clk), .reset(rst), .bus(ifw.slave));
  pwm_mixer_n #(.NUM_CH(3), .WIDTH(8), .DEBOUNCE_DIV(4), .SATURATE(1), .INIT_LEVEL(253))
    u_h (.clk(clk), .reset(rst), .bus(ifh.slave));

  always #5 clk = ~clk;

  // High-cycle count of the saturating DUT's last complete period, per channel.
  initial for (int i = 0; i < 3; i++) begin run_hi[i] = 0; last_hi[i] = 0; end
  always @(negedge clk) begin
    if (ifs.sync) sync_cnt++;
    for (int i = 0; i < 3; i++) begin
      if (ifs.sync) begin
        last_hi[i] = run_hi[i];
        run_hi[i]  = int'(ifs.pwm_out[i]);
      end else begin
        run_hi[i]  = run_hi[i] + int'(ifs.pwm_out[i]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sync();
    bit seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      hold(1);
      if (ifs.sync) begin seen = 1'b1; break; end
    end
    chk("sync_seen", 32'(seen), 32'd1);
    #1;
  endtask

  task automatic set_a(input int d, input int ch, input logic v);
    ea[d][ch] = v;
  endtask

  task automatic set_b(input int d, input int ch, input logic v);
    eb[d][ch] = v;
  endtask

  task automatic detent(input int d, input int ch, input bit cw);
    if (cw) begin
      set_a(d, ch, 1'b1); hold(20);
      set_b(d, ch, 1'b1); hold(20);
      set_a(d, ch, 1'b0); hold(20);
      set_b(d, ch, 1'b0); hold(20);
    end else begin
      set_b(d, ch, 1'b1); hold(20);
      set_a(d, ch, 1'b1); hold(20);
      set_b(d, ch, 1'b0); hold(20);
      set_a(d, ch, 1'b0); hold(20);
    end
  endtask

  initial begin
    int n;
    int s0;
    rst = 1'b1;
    en  = 1'b1;
    for (int d = 0; d < 3; d++) begin ea[d] = '0; eb[d] = '0; end
    hold(3);

    // Reset values
    chk("rst_pwm",     32'(ifs.pwm_out), 32'h0);
    chk("rst_sync",    32'(ifs.sync),    32'h0);
    chk("rst_level",   32'(ifs.level_o), 32'h000000);
    chk("rst_oeb",     32'(ifs.io_oeb),  32'h0);
    chk("rst_level_h", 32'(ifh.level_o), 32'hFDFDFD);

    // First sync one clock after release, then every 256 clocks
    rst = 1'b0;
    hold(1);
    chk("first_sync", 32'(ifs.sync), 32'd1);
    n = -1;
    for (int k = 1; k <= 400; k++) begin
      hold(1);
      if (ifs.sync) begin n = k; break; end
    end
    chk("sync_period", 32'(n), 32'd256);

    // Five clockwise detents on channel 1
    for (int i = 0; i < 5; i++) detent(0, 1, 1'b1);
    chk("cw5_level", 32'(ifs.level_o), 32'h000500);
    wait_sync();
    wait_sync();
    chk("cw5_hi_ch1", 32'(last_hi[1]), 32'd5);
    chk("cw5_hi_ch0", 32'(last_hi[0]), 32'd0);

    // Level reaches 64 in the middle of a period
    for (int i = 0; i < 58; i++) detent(0, 1, 1'b1);
    chk("lvl63", 32'(ifs.level_o), 32'h003F00);
    wait_sync();
    detent(0, 1, 1'b1);
    chk("lvl64", 32'(ifs.level_o), 32'h004000);
    wait_sync();
    chk("midper_old_duty", 32'(last_hi[1]), 32'd63);
    wait_sync();
    chk("midper_new_duty", 32'(last_hi[1]), 32'd64);

    // Saturation and wrap at both ends
    for (int i = 0; i < 3; i++) detent(0, 2, 1'b0);
    chk("sat_low", 32'(ifs.level_o), 32'h004000);
    detent(2, 0, 1'b1);
    detent(2, 0, 1'b1);
    chk("sat_reach_max", 32'(ifh.level_o), 32'hFDFDFF);
    detent(2, 0, 1'b1);
    detent(2, 0, 1'b1);
    chk("sat_high", 32'(ifh.level_o), 32'hFDFDFF);
    detent(2, 1, 1'b0);
    chk("sat_dec", 32'(ifh.level_o), 32'hFDFCFF);
    detent(1, 0, 1'b0);
    chk("wrap_low", 32'(ifw.level_o), 32'h0000FF);
    detent(1, 0, 1'b1);
    chk("wrap_high", 32'(ifw.level_o), 32'h000000);

    // Debounce: short glitch ignored, 16-clock stable rise counts
    set_a(0, 0, 1'b1); hold(3);
    set_a(0, 0, 1'b0); hold(20);
    chk("glitch", 32'(ifs.level_o), 32'h004000);
    set_a(0, 0, 1'b1); hold(16);
    set_a(0, 0, 1'b0); hold(20);
    chk("stable_rise", 32'(ifs.level_o), 32'h004001);

    // Enable dropped mid-period, step applied while disabled
    wait_sync();
    hold(50);
    en = 1'b0;
    hold(2);
    chk("dis_pwm",  32'(ifs.pwm_out), 32'h0);
    chk("dis_sync", 32'(ifs.sync),    32'h0);
    s0 = sync_cnt;
    detent(0, 2, 1'b1);
    chk("dis_level", 32'(ifs.level_o), 32'h004001);
    chk("dis_nosync", 32'(sync_cnt), 32'(s0));
    chk("dis_pwm2",  32'(ifs.pwm_out), 32'h0);
    en = 1'b1;
    hold(1);
    chk("reen_sync", 32'(ifs.sync), 32'd1);
    hold(3);
    chk("reen_level", 32'(ifs.level_o), 32'h004001);

    // Asynchronous reset mid-period
    wait_sync();
    hold(10);
    chk("pre_rst_pwm", 32'(ifs.pwm_out), 32'b010);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pwm",     32'(ifs.pwm_out), 32'h0);
    chk("arst_sync",    32'(ifs.sync),    32'h0);
    chk("arst_level",   32'(ifs.level_o), 32'h000000);
    chk("arst_level_h", 32'(ifh.level_o), 32'hFDFDFD);
    chk("arst_oeb",     32'(ifs.io_oeb),  32'h0);
    hold(2);
    rst = 1'b0;
    hold(1);
    chk("post_rst_sync", 32'(ifs.sync), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
